imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and
// field widths of the length and checksum fields.
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        RUN     = 3'd4,
        FAIL    = 3'd5
    } load_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into
// 32-bit instruction-memory writes, then releases the CPU on a good checksum.
//
// state   | meaning
// LEN_HI  | waiting for length MSB
// LEN_LO  | waiting for length LSB, range-check N
// PAYLOAD | assembling big-endian words, one write per 4 bytes
// CSUM    | waiting for the checksum byte
// RUN     | image verified, CPU released (terminal)
// FAIL    | bad length or checksum, CPU held (terminal)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

    load_state_t       state, state_nxt;
    logic              armed;
    logic [LEN_W-1:0]  n_reg;
    logic [LEN_W-1:0]  word_cnt;
    logic [1:0]        byte_cnt;
    logic [CSUM_W-1:0] csum;
    logic [23:0]       word_sr;
    logic [LEN_W-1:0]  len_full;
    logic              xfer;
    logic              last_byte;

    // armed keeps byte_ready low while in reset and raises it on the first edge after
    assign byte_ready = armed && (state != RUN) && (state != FAIL);
    assign xfer       = byte_valid && byte_ready;
    assign len_full   = {n_reg[LEN_W-1:8], byte_data};
    assign last_byte  = (byte_cnt == 2'd3) && (word_cnt == n_reg - LEN_W'(1));

    assign cpu_hold = (state != RUN);
    assign done     = (state == RUN);
    assign err      = (state == FAIL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LEN_HI;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LEN_HI: if (xfer) state_nxt = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_full == '0)               state_nxt = CSUM;
                    else if (32'(len_full) > MAX_W32) state_nxt = FAIL;
                    else                              state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: if (xfer && last_byte) state_nxt = CSUM;
            CSUM: begin
                if (xfer) state_nxt = (byte_data == csum) ? RUN : FAIL;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed      <= 1'b0;
            n_reg      <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
            word_sr    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
        end else begin
            armed   <= 1'b1;
            imem_we <= 1'b0;
            if (xfer) begin
                case (state)
                    LEN_HI: n_reg[LEN_W-1:8] <= byte_data;
                    LEN_LO: n_reg[7:0]       <= byte_data;
                    PAYLOAD: begin
                        csum     <= csum ^ byte_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        word_sr  <= {word_sr[15:0], byte_data};
                        // word complete: strobe next cycle while the stream keeps flowing
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= {word_sr, byte_data};
                            imem_addr  <= BASE_ADDR + 32'({word_cnt, 2'b00});
                            word_cnt   <= word_cnt + LEN_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams are built from a word list by a
// queue-based model that predicts every write, its timing and the final outcome.
module tb_imem_loader;

    localparam int          MAXW = 256;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          xfers       = 0;
    int          writes_seen = 0;
    logic [31:0] words[$];
    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic monitor();
        if (imem_we === 1'b1) begin
            if (exp_addr.size() == 0) begin
                check("unexpected_we", 32'(imem_we), 32'd0);
            end else begin
                writes_seen++;
                check("we_addr", imem_addr, exp_addr.pop_front());
                check("we_data", imem_wdata, exp_data.pop_front());
                // the strobe must follow the 4th payload byte of each word by one cycle
                check("we_timing", 32'(xfers - 2), 32'(4 * writes_seen));
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, output logic took);
        byte_valid = v;
        byte_data  = v ? d : 8'($urandom);
        took       = v && byte_ready;
        @(posedge clk);
        #1;
        if (took) xfers++;
        monitor();
    endtask

    task automatic do_reset();
        logic took;
        exp_addr.delete();
        exp_data.delete();
        reset      = 1'b0;
        byte_valid = 1'b0;
        #2;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", imem_addr, BASE);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) step(1'b1, 8'h00, took);
        check("rst_hold_ready", 32'(byte_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("ready_before_edge", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(byte_ready), 32'd1);
        xfers       = 0;
        writes_seen = 0;
    endtask

    task automatic gen_words(input int n);
        words.delete();
        for (int k = 0; k < n; k++) words.push_back($urandom);
    endtask

    // Reference stream: length, big-endian words, XOR of payload bytes
    task automatic make_stream(input int n, input bit corrupt);
        logic [7:0]  x;
        logic [15:0] len;
        logic [7:0]  b8;
        len = 16'(n);
        x   = 8'h00;
        stream.delete();
        exp_addr.delete();
        exp_data.delete();
        stream.push_back(len[15:8]);
        stream.push_back(len[7:0]);
        if (n <= MAXW) begin
            for (int k = 0; k < n; k++) begin
                for (int b = 3; b >= 0; b--) begin
                    b8 = words[k][8*b +: 8];
                    stream.push_back(b8);
                    x ^= b8;
                end
                exp_addr.push_back(BASE + 32'(4 * k));
                exp_data.push_back(words[k]);
            end
            stream.push_back(corrupt ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
        end
    endtask

    task automatic feed(input int pct, input int nbytes, input int budget);
        int   idx;
        int   cyc;
        logic took;
        idx = 0;
        cyc = 0;
        while (idx < nbytes && cyc < budget) begin
            step(1'(int'($urandom_range(0, 99)) < pct), stream[idx], took);
            if (took) idx++;
            cyc++;
        end
        byte_valid = 1'b0;
        check("bytes_accepted", 32'(idx), 32'(nbytes));
    endtask

    task automatic check_end(input bit exp_run);
        check("done", 32'(done), 32'(exp_run));
        check("err", 32'(err), 32'(!exp_run));
        check("cpu_hold", 32'(cpu_hold), 32'(!exp_run));
        check("byte_ready_term", 32'(byte_ready), 32'd0);
        check("writes_left", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic run_case(input int n, input bit corrupt, input int pct);
        bit   exp_run;
        int   nb;
        logic took;
        do_reset();
        make_stream(n, corrupt);
        exp_run = (n <= MAXW) && !corrupt;
        nb      = (n > MAXW) ? 2 : stream.size();
        check("pre_cpu_hold", 32'(cpu_hold), 32'd1);
        check("pre_done", 32'(done), 32'd0);
        feed(pct, nb, 20 * nb + 50);
        check_end(exp_run);
        repeat (4) step(1'b1, 8'($urandom), took);
        check_end(exp_run);
        check("xfers_stable", 32'(xfers), 32'(nb));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // two-word reference image; checksum comes from the XOR rule
        words = '{32'h2008_0005, 32'h0109_5020};
        run_case(2, 1'b0, 100);
        run_case(2, 1'b1, 100);
        run_case(2, 1'b0, 50);
        run_case(2, 1'b0, 30);

        run_case(257, 1'b0, 100);
        run_case(0, 1'b0, 100);
        run_case(0, 1'b1, 100);

        gen_words(MAXW);
        run_case(MAXW, 1'b0, 90);
        gen_words(1);
        run_case(1, 1'b0, 60);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 24);
            gen_words(n);
            run_case(n, 1'($urandom_range(0, 1)), $urandom_range(35, 100));
        end

        // abort mid-load after 6 payload bytes, then resend cleanly
        words = '{32'h2008_0005, 32'h0109_5020};
        do_reset();
        make_stream(2, 1'b0);
        feed(100, 8, 100);
        check("abort_writes", 32'(writes_seen), 32'd1);
        do_reset();
        check("abort_no_we", 32'(imem_we), 32'd0);
        make_stream(2, 1'b0);
        feed(70, stream.size(), 200);
        check_end(1'b1);
        check("restart_writes", 32'(writes_seen), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
